// File: rtl/ceespu_pkg.sv
// Shared constants and types for the ceespu register-file write side.
package ceespu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_SEL_W  = 5;
    localparam int NUM_REGS   = 32;
    localparam int SP_REG     = 18;
    localparam int WB_ENTRY_W = REG_SEL_W + XLEN;

    localparam logic [REG_SEL_W-1:0] SEL_RST  = '0;
    localparam logic [XLEN-1:0]      DATA_RST = '0;
    localparam logic [NUM_REGS-1:0]  BUSY_RST = '0;

    // One buffered long-latency result: destination register plus its value.
    typedef struct packed {
        logic [REG_SEL_W-1:0] sel;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/ceespu_wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until a free write slot.
module ceespu_wb_fifo
    import ceespu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WB_ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // Full/empty come from registered count, so a pop never frees a slot for a same-cycle push.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
        if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; clearing them on reset discards any queued entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/ceespu_writeback.sv
// Register-file write master: ALU results win, buffered long-latency results fill idle slots.
module ceespu_writeback
    import ceespu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_alu_valid,
    input  logic [REG_SEL_W-1:0] I_alu_sel,
    input  logic [XLEN-1:0]      I_alu_data,
    input  logic                 I_mem_valid,
    output logic                 O_mem_ready,
    input  logic [REG_SEL_W-1:0] I_mem_sel,
    input  logic [XLEN-1:0]      I_mem_data,
    input  logic                 I_issue_valid,
    input  logic [REG_SEL_W-1:0] I_issue_sel,
    output logic [NUM_REGS-1:0]  O_busy,
    output logic                 O_alu_hold,
    output logic                 O_we,
    output logic [REG_SEL_W-1:0] O_selD,
    output logic [XLEN-1:0]      O_dataD
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    wb_entry_t            pushEntry;
    wb_entry_t            headEntry;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [CNT_W-1:0]     fifoCount;
    logic                 fifoPush;
    logic                 fifoPop;

    logic                 we_q, we_d;
    logic [REG_SEL_W-1:0] selD_q, selD_d;
    logic [XLEN-1:0]      dataD_q, dataD_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [7:0]           starve_q, starve_d;

    assign pushEntry = '{sel: I_mem_sel, data: I_mem_data};
    assign O_mem_ready = !fifoFull && !I_rst;
    assign fifoPush = I_mem_valid && O_mem_ready;
    assign fifoPop  = !I_alu_valid && !fifoEmpty;

    ceespu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clk_i   (I_clk),
        .rst_i   (I_rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (pushEntry),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Arbitration, scoreboard update and starvation tracking for the next cycle.
    always_comb begin
        we_d     = 1'b0;
        selD_d   = selD_q;
        dataD_d  = dataD_q;
        busy_d   = busy_q;
        starve_d = starve_q;

        if (I_alu_valid) begin
            we_d    = 1'b1;
            selD_d  = I_alu_sel;
            dataD_d = I_alu_data;
        end else if (fifoPop) begin
            we_d    = 1'b1;
            selD_d  = headEntry.sel;
            dataD_d = headEntry.data;
        end

        // Clear before set so a same-cycle issue to the committing register stays busy.
        if (fifoPop)       busy_d[headEntry.sel] = 1'b0;
        if (I_issue_valid) busy_d[I_issue_sel]   = 1'b1;

        if (fifoEmpty || fifoPop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // All architecturally visible state is registered; reset drops any pending write.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            we_q     <= 1'b0;
            selD_q   <= SEL_RST;
            dataD_q  <= DATA_RST;
            busy_q   <= BUSY_RST;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            selD_q   <= selD_d;
            dataD_q  <= dataD_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    assign O_we       = we_q;
    assign O_selD     = selD_q;
    assign O_dataD    = dataD_q;
    assign O_busy     = busy_q;
    assign O_alu_hold = (starve_q == STARVE_LIM) || fifoFull;

    // Decode must stall on busy registers unless that register's write commits this same cycle.
    issueNotBusy: assert property (@(posedge I_clk) disable iff (I_rst)
        I_issue_valid |-> (!busy_q[I_issue_sel] || (fifoPop && headEntry.sel == I_issue_sel)));

endmodule

// File: tb/tb_ceespu_writeback.sv
// Directed self-checking bench for ceespu_writeback (DEPTH=4, STARVE_MAX=8).
module tb_ceespu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [4:0]  aluSel;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [4:0]  memSel;
    logic [31:0] memData;
    logic        issueValid;
    logic [4:0]  issueSel;
    logic [31:0] busy;
    logic        aluHold;
    logic        we;
    logic [4:0]  selD;
    logic [31:0] dataD;

    int checkCount = 0;
    int failCount  = 0;

    ceespu_writeback #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_alu_valid   (aluValid),
        .I_alu_sel     (aluSel),
        .I_alu_data    (aluData),
        .I_mem_valid   (memValid),
        .O_mem_ready   (memReady),
        .I_mem_sel     (memSel),
        .I_mem_data    (memData),
        .I_issue_valid (issueValid),
        .I_issue_sel   (issueSel),
        .O_busy        (busy),
        .O_alu_hold    (aluHold),
        .O_we          (we),
        .O_selD        (selD),
        .O_dataD       (dataD)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic applyStimulus(input logic av, input logic [4:0] as, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] ms, input logic [31:0] md,
                                 input logic iv, input logic [4:0] is);
        aluValid   = av;
        aluSel     = as;
        aluData    = ad;
        memValid   = mv;
        memSel     = ms;
        memData    = md;
        issueValid = iv;
        issueSel   = is;
        @(posedge clk);
        #1;
    endtask

    // One comparison against a hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        aluValid   = 1'b0;
        aluSel     = '0;
        aluData    = '0;
        memValid   = 1'b0;
        memSel     = '0;
        memData    = '0;
        issueValid = 1'b0;
        issueSel   = '0;

        // Reset state
        #1;
        checkOutput("rst_we",    32'(we),      32'd0);
        checkOutput("rst_sel",   32'(selD),    32'd0);
        checkOutput("rst_data",  dataD,        32'd0);
        checkOutput("rst_busy",  busy,         32'd0);
        checkOutput("rst_hold",  32'(aluHold), 32'd0);
        checkOutput("rst_ready", 32'(memReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 32'(memReady), 32'd1);

        // ALU only
        $display("[TB] ALU-only write");
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checkOutput("alu_we",   32'(we),   32'd1);
        checkOutput("alu_sel",  32'(selD), 32'd5);
        checkOutput("alu_data", dataD,     32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_we_off",  32'(we),   32'd0);
        checkOutput("alu_sel_hold", 32'(selD), 32'd5);
        checkOutput("alu_busy",    busy,      32'd0);

        // Memory path with scoreboard
        $display("[TB] memory path and scoreboard");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
        checkOutput("mem_busy_set", busy, 32'h0000_0080);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h1234, 0, 0);
        checkOutput("mem_no_bypass", 32'(we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mem_we",    32'(we),   32'd1);
        checkOutput("mem_sel",   32'(selD), 32'd7);
        checkOutput("mem_data",  dataD,     32'h1234);
        checkOutput("mem_busy_clr", busy,   32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mem_we_off", 32'(we), 32'd0);

        // Contention and starvation
        $display("[TB] starvation");
        applyStimulus(1, 5'd10, 32'hA0A0, 1, 5'd3, 32'h33, 1, 5'd3);
        checkOutput("stv_busy", busy, 32'h0000_0008);
        repeat (7) applyStimulus(1, 5'd10, 32'hA0A0, 0, 0, 0, 0, 0);
        checkOutput("stv_hold_7",  32'(aluHold), 32'd0);
        checkOutput("stv_alu_sel", 32'(selD),    32'd10);
        applyStimulus(1, 5'd10, 32'hA0A0, 0, 0, 0, 0, 0);
        checkOutput("stv_hold_8", 32'(aluHold), 32'd1);
        applyStimulus(1, 5'd11, 32'hA1A1, 0, 0, 0, 0, 0);
        checkOutput("stv_alu_wins_hold", 32'(selD), 32'd11);
        checkOutput("stv_hold_sat", 32'(aluHold), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stv_commit_sel",  32'(selD),    32'd3);
        checkOutput("stv_commit_data", dataD,        32'h33);
        checkOutput("stv_hold_off",    32'(aluHold), 32'd0);
        checkOutput("stv_busy_clr",    busy,         32'd0);

        // FIFO full under continuous ALU traffic
        $display("[TB] FIFO full");
        for (int i = 1; i <= 4; i++) begin
            checkOutput("full_ready_before", 32'(memReady), 32'd1);
            applyStimulus(1, 5'd20, 32'hC0DE, 1, 5'(i), 32'h100 + 32'(i), 0, 0);
        end
        checkOutput("full_ready", 32'(memReady), 32'd0);
        checkOutput("full_hold",  32'(aluHold),  32'd1);
        applyStimulus(1, 5'd20, 32'hC0DE, 1, 5'd5, 32'h105, 0, 0);
        checkOutput("full_still_ready", 32'(memReady), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("drain_we",   32'(we),   32'd1);
            checkOutput("drain_sel",  32'(selD), 32'(i));
            checkOutput("drain_data", dataD,     32'h100 + 32'(i));
            if (i == 1) checkOutput("drain_ready", 32'(memReady), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_done_we", 32'(we), 32'd0);

        // Simultaneous set and clear of the same busy bit
        $display("[TB] simultaneous issue and commit");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        applyStimulus(1, 5'd20, 32'h2020, 1, 5'd9, 32'h99, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9);
        checkOutput("simul_sel",  32'(selD), 32'd9);
        checkOutput("simul_data", dataD,     32'h99);
        checkOutput("simul_busy", busy,      32'h0000_0200);

        // Asynchronous reset mid-drain
        $display("[TB] async reset mid-drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 5'd21, 32'h2121, 1, 5'd11 + 5'(i), 32'h200 + 32'(i), 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_we",  32'(we),   32'd1);
        checkOutput("pre_rst_sel", 32'(selD), 32'd11);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_we",    32'(we),       32'd0);
        checkOutput("arst_busy",  busy,          32'd0);
        checkOutput("arst_ready", 32'(memReady), 32'd0);
        checkOutput("arst_sel",   32'(selD),     32'd0);
        @(posedge clk);
        #1;
        checkOutput("arst_hold_we", 32'(we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("arst_rel_ready", 32'(memReady), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("arst_no_stale1", 32'(we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("arst_no_stale2", 32'(we), 32'd0);
        checkOutput("arst_busy_after", busy,   32'd0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
